lif_scheduler: RTL
==================

Name: lif_scheduler

Overview:
- Time-multiplexed scheduler for the leaky integrate-and-fire (LIF) neuron datapath.
- One shared update engine serves N neurons. On each timestep tick it sweeps all neurons, one per clock, then publishes the spike vector.
- The tick comes from an internal prescaler (all-ones match) or an external step strobe.
- Per-neuron input weights are set at run time through a small config write port. The block sits between the tt_um top-level pins and the spike outputs.

Parameters:
- N, 8, number of neurons swept per tick (2..16).
- V_W, 8, membrane potential width (unsigned).
- W_W, 4, per-neuron weight width (unsigned).
- W_INIT, 4'd15, reset value of every weight.
- THRESH, 200, firing threshold; fire when V_next >= THRESH.
- LEAK_SHIFT, 3, leak = V >> LEAK_SHIFT.
- PRESCALE_W, 23, prescaler counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ena  in  1  prescaler count enable
- step  in  1  external tick strobe, OR'd with the prescaler tick
- i_in  in  8  input current, unsigned; sampled once per tick
- cfg_we  in  1  weight write strobe
- cfg_addr  in  clog2(N)  neuron index for the weight write
- cfg_data  in  W_W  weight value
- spikes  out  N  spike vector of the last completed sweep
- frame_done  out  1  one-cycle pulse when spikes updates
- busy  out  1  sweep in progress
- overrun  out  1  sticky; a tick arrived while busy

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-low on `rst_n`, sampled at the posedge.
- Reset values:
  - spikes = 0, frame_done = 0, busy = 0, overrun = 0.
  - All membranes = 0; all weights = W_INIT; prescaler = 0; state = IDLE.
- Reset mid-sweep aborts immediately. No partial spike vector is published.
- Prescaler: increments each cycle while ena = 1. ptick = prescaler all-ones. tick = ptick | step.
- FSM states: IDLE, LOAD, UPDATE, COMMIT.
  - IDLE: on tick go to LOAD.
  - LOAD (1 cycle): latch i_in into i_q; idx = 0; clear the spike accumulator.
  - UPDATE (N cycles): process neuron idx; idx++; after idx = N-1 go to COMMIT.
  - COMMIT (1 cycle): spikes <= accumulator; frame_done <= 1; then IDLE.
- Latency: tick sampled in cycle c.
  - busy is high in cycles c+1 .. c+N+2.
  - spikes and frame_done are visible in cycle c+N+3; frame_done lasts exactly one cycle.
- Tick while not IDLE: the tick is dropped and overrun <= 1 (sticky until reset). The sweep continues unaffected.
- Update arithmetic for neuron k, unsigned, internal width V_W+2:
  - prod = (i_q * w[k]) >> 4
  - sum = V[k] - (V[k] >> LEAK_SHIFT) + prod
  - Saturate sum to 2^V_W - 1.
  - If sum >= THRESH: accumulator bit k = 1 and V[k] <= 0. Otherwise V[k] <= sum.
- Config writes: accepted in any state.
  - A write to neuron k in the same cycle that neuron k is updated is not used for that update (the old weight is used); the new weight applies from the next tick.
  - A write while rst_n = 0 is ignored.
- i_in changes after LOAD have no effect until the next tick.

Decomposition:
- Package lif_pkg holds:
  - state enum {IDLE, LOAD, UPDATE, COMMIT};
  - constants for the default THRESH and LEAK_SHIFT;
  - the index width function clog2(N).
- Sub-module lif_update: purely combinational one-neuron step.
  - In: V, w, i_q.
  - Out: V_next, fire.
- The scheduler holds the FSM, prescaler, membrane/weight register files and output registers.

Test Plan:
- Reset, then step once with i_in = 64 and all weights 15.
  - Membrane sequence per tick is 60, 113, 159; the 4th tick fires.
  - spikes = 8'hFF at cycle c+N+3 of the 4th tick (c+11 for N = 8).
  - frame_done is one cycle; all V = 0 afterwards.
- Write weight 0 to neuron 3, then 4 ticks at i_in = 64.
  - spikes = 8'hF7 on the 4th tick; V[3] stays 0 throughout.
- i_in = 255, weights 15.
  - prod = 239 after saturation; every neuron fires on every tick, spikes = 8'hFF each frame.
- Assert step 3 cycles after a tick (mid-UPDATE).
  - overrun = 1 and stays 1.
  - Only one frame_done occurs; busy timing is unchanged.
- Pull rst_n low during UPDATE with idx = 4.
  - Next cycle: busy = 0 and spikes = 0.
  - The next tick starts from V = 0 and weights = W_INIT.
- ena = 1, step = 0, PRESCALE_W overridden to 4.
  - A tick occurs every 16 cycles; frame_done pulses every 16 cycles with no overrun.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron scheduler: FSM state encoding,
// default neuron constants and the neuron-index width helper.
// Latency: n/a (types and constants only). Backpressure: n/a.
package lif_pkg;

    // Sweep FSM. The encodings are fixed so waveforms match older captures.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        UPDATE = 2'd2,
        COMMIT = 2'd3
    } lif_state_e;

    localparam int THRESH_DEF     = 200;
    localparam int LEAK_SHIFT_DEF = 3;

    // Width of a neuron index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lif_update.sv
// One leaky integrate-and-fire step for a single neuron (pure combinational).
// Latency: 0 cycles, result is valid in the same cycle as the inputs.
// Backpressure: none; the scheduler presents one neuron per clock.
// Ports: v (current membrane), w (weight), i_q (latched input current)
//        -> v_next (membrane to write back), fire (threshold reached).
module lif_update import lif_pkg::*; #(
    parameter int V_W        = 8,
    parameter int W_W        = 4,
    parameter int I_W        = 8,
    parameter int THRESH     = THRESH_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
    input  logic [V_W-1:0] v,
    input  logic [W_W-1:0] w,
    input  logic [I_W-1:0] i_q,
    output logic [V_W-1:0] v_next,
    output logic           fire
);

    // Two guard bits: leak never underflows and prod+V stays below 4x range.
    localparam int SW = V_W + 2;
    localparam int PW = I_W + W_W;
    localparam logic [SW-1:0] VMAX = SW'({V_W{1'b1}});
    localparam logic [SW-1:0] THR  = SW'(THRESH);

    logic [PW-1:0] mult;
    logic [SW-1:0] prod;
    logic [SW-1:0] sum;
    logic [SW-1:0] sat;

    always_comb begin
        mult   = PW'(i_q) * PW'(w);
        prod   = SW'(mult >> 4);
        sum    = SW'(v) - SW'(v >> LEAK_SHIFT) + prod;
        sat    = (sum > VMAX) ? VMAX : sum;
        // Threshold is checked after saturation so a clipped value can fire.
        fire   = (sat >= THR);
        v_next = fire ? '0 : sat[V_W-1:0];
    end

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF scheduler: on each tick sweeps N neurons through one
// shared update engine, then publishes the spike vector.
// Latency: tick in cycle c -> busy c+1..c+N+2, spikes/frame_done at c+N+3.
// Backpressure: none; a tick while busy is dropped and flags sticky overrun.
// Ports: clk, rst_n (sync, active-low), ena (prescaler enable), step
//        (external tick), i_in (input current), cfg_we/cfg_addr/cfg_data
//        (weight write), spikes, frame_done, busy, overrun.
module lif_scheduler import lif_pkg::*; #(
    parameter int             N          = 8,
    parameter int             V_W        = 8,
    parameter int             W_W        = 4,
    parameter logic [W_W-1:0] W_INIT     = 4'd15,
    parameter int             THRESH     = THRESH_DEF,
    parameter int             LEAK_SHIFT = LEAK_SHIFT_DEF,
    parameter int             PRESCALE_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 step,
    input  logic [7:0]           i_in,
    input  logic                 cfg_we,
    input  logic [idx_w(N)-1:0]  cfg_addr,
    input  logic [W_W-1:0]       cfg_data,
    output logic [N-1:0]         spikes,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 overrun
);

    localparam int            AW   = idx_w(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    lif_state_e          state;
    logic [PRESCALE_W-1:0] presc;
    logic [AW-1:0]       idx;
    logic [7:0]          i_q;
    logic [N-1:0]        acc;
    logic [V_W-1:0]      v_mem [N];
    logic [W_W-1:0]      w_mem [N];

    logic                ptick;
    logic                tick;
    logic [V_W-1:0]      upd_v_next;
    logic                upd_fire;

    assign ptick = &presc;
    assign tick  = ptick | step;
    assign busy  = (state != IDLE);

    // The engine reads the registered weight, so a config write landing in
    // the same cycle as this neuron's update only takes effect next tick.
    lif_update #(
        .V_W        (V_W),
        .W_W        (W_W),
        .I_W        (8),
        .THRESH     (THRESH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_update (
        .v      (v_mem[idx]),
        .w      (w_mem[idx]),
        .i_q    (i_q),
        .v_next (upd_v_next),
        .fire   (upd_fire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            idx        <= '0;
            i_q        <= '0;
            acc        <= '0;
            spikes     <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            for (int k = 0; k < N; k++) begin
                v_mem[k] <= '0;
                w_mem[k] <= W_INIT;
            end
        end else begin
            frame_done <= 1'b0;

            if (ena) begin
                presc <= presc + 1'b1;
            end

            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            if (cfg_we && (int'(cfg_addr) < N)) begin
                w_mem[cfg_addr] <= cfg_data;
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    i_q   <= i_in;
                    idx   <= '0;
                    acc   <= '0;
                    state <= UPDATE;
                end
                UPDATE: begin
                    v_mem[idx] <= upd_v_next;
                    acc[idx]   <= upd_fire;
                    if (idx == LAST) begin
                        state <= COMMIT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                COMMIT: begin
                    spikes     <= acc;
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
